// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one DATA_W-bit adder among NUM_REQ requesters, with a
// one-entry registered result stage. Define ADDER_ARBITER_FLAGS_EN to add carry/overflow outputs.
module adder_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 64,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_sum,
`ifdef ADDER_ARBITER_FLAGS_EN
  output logic                      rsp_carry,
  output logic                      rsp_ovf,
`endif
  output logic [ID_W-1:0]           rsp_id
);

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_sum_q, rsp_sum_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic              can_accept;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   scan_idx;
  logic              xfer;
  logic [DATA_W-1:0] a_sel, b_sel;

  assign can_accept = !rsp_valid_q || rsp_ready;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Gated by reset so no grant is visible while reset is asserted.
  assign xfer = reset && can_accept && grant_found;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant_idx] = 1'b1;
  end

  assign a_sel = req_a[32'(grant_idx)*DATA_W +: DATA_W];
  assign b_sel = req_b[32'(grant_idx)*DATA_W +: DATA_W];

`ifdef ADDER_ARBITER_FLAGS_EN
  logic [DATA_W:0] sum_full;
  logic            rsp_carry_q, rsp_carry_d;
  logic            rsp_ovf_q, rsp_ovf_d;
  logic            ovf_w;

  assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};
  assign ovf_w    = (a_sel[DATA_W-1] == b_sel[DATA_W-1]) &&
                    (sum_full[DATA_W-1] != a_sel[DATA_W-1]);
`else
  logic [DATA_W-1:0] sum_full;

  assign sum_full = a_sel + b_sel;
`endif

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef ADDER_ARBITER_FLAGS_EN
    rsp_carry_d = rsp_carry_q;
    rsp_ovf_d   = rsp_ovf_q;
`endif
    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_sum_d   = sum_full[DATA_W-1:0];
      rsp_id_d    = grant_idx;
      rr_ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(grant_idx + 1'b1);
`ifdef ADDER_ARBITER_FLAGS_EN
      rsp_carry_d = sum_full[DATA_W];
      rsp_ovf_d   = ovf_w;
`endif
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      rr_ptr_q    <= '0;
`ifdef ADDER_ARBITER_FLAGS_EN
      rsp_carry_q <= 1'b0;
      rsp_ovf_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef ADDER_ARBITER_FLAGS_EN
      rsp_carry_q <= rsp_carry_d;
      rsp_ovf_q   <= rsp_ovf_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;
`ifdef ADDER_ARBITER_FLAGS_EN
  assign rsp_carry = rsp_carry_q;
  assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed testbench for adder_arbiter (NUM_REQ=4, DATA_W=64).
module tb_adder_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 64;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_sum;
  logic [1:0]                rsp_id;
`ifdef ADDER_ARBITER_FLAGS_EN
  logic                      rsp_carry;
  logic                      rsp_ovf;
`endif

  int checks = 0;
  int errors = 0;

  adder_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
`ifdef ADDER_ARBITER_FLAGS_EN
    .rsp_carry (rsp_carry),
    .rsp_ovf   (rsp_ovf),
`endif
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    req_a[i*DATA_W +: DATA_W] = a;
    req_b[i*DATA_W +: DATA_W] = b;
  endtask

  task automatic reset_pulse();
    req_valid = '0;
    rsp_ready = 1'b1;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %0b want 0", rsp_valid);
    end
    checks++;
    if (rsp_sum !== '0 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL reset_sum_id got %0h/%0d want 0/0", rsp_sum, rsp_id);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready got %b want 0000", req_ready);
    end
    req_valid = '0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    set_op(0, 64'h10, 64'h20);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_ready got %b want 0001", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 64'h30 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL single_rsp got v%0b %0h id%0d want v1 30 id0", rsp_valid, rsp_sum, rsp_id);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 64'h30) begin
      errors++; $display("FAIL drain got v%0b %0h want v0 30", rsp_valid, rsp_sum);
    end
  endtask

  task automatic test_round_robin();
    reset_pulse();
    for (int i = 0; i < 4; i++) set_op(i, 64'(i), 64'd100);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (req_ready !== 4'(1 << (c % 4))) begin
        errors++;
        $display("FAIL rr_grant%0d got %b want %b", c, req_ready, 4'(1 << (c % 4)));
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 64'(100 + c % 4) || rsp_id !== 2'(c % 4)) begin
        errors++;
        $display("FAIL rr_rsp%0d got v%0b %0d id%0d want v1 %0d id%0d", c, rsp_valid,
                 rsp_sum, rsp_id, 100 + c % 4, c % 4);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    step();  // drain the last round-robin result
    set_op(1, 64'd5, 64'd6);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_grant got %b want 0010", req_ready);
    end
    step();
    set_op(2, 64'd7, 64'd8);
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_sum !== 64'd11 ||
          rsp_id !== 2'd1) begin
        errors++;
        $display("FAIL bp_stall%0d got rdy%b v%0b %0d id%0d want 0000 v1 11 id1", c,
                 req_ready, rsp_valid, rsp_sum, rsp_id);
      end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_release got %b want 0100", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 64'd15 || rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL bp_swap got v%0b %0d id%0d want v1 15 id2", rsp_valid, rsp_sum, rsp_id);
    end
    step();
  endtask

  task automatic test_overflow();
    // rr_ptr is 3 after requester 2 won
    set_op(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    step();
    checks++;
    if (rsp_sum !== 64'h0 || rsp_id !== 2'd3) begin
      errors++; $display("FAIL wrap_sum got %0h id%0d want 0 id3", rsp_sum, rsp_id);
    end
`ifdef ADDER_ARBITER_FLAGS_EN
    checks++;
    if (rsp_carry !== 1'b1 || rsp_ovf !== 1'b0) begin
      errors++; $display("FAIL carry_flags got c%0b o%0b want c1 o0", rsp_carry, rsp_ovf);
    end
`endif
    set_op(3, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
    step();
    req_valid = '0;
    checks++;
    if (rsp_sum !== 64'h8000_0000_0000_0000) begin
      errors++; $display("FAIL ovf_sum got %0h want 8000000000000000", rsp_sum);
    end
`ifdef ADDER_ARBITER_FLAGS_EN
    checks++;
    if (rsp_carry !== 1'b0 || rsp_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_flags got c%0b o%0b want c0 o1", rsp_carry, rsp_ovf);
    end
`endif
    step();
  endtask

  task automatic test_reset_mid();
    set_op(1, 64'd1, 64'd2);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    step();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre got v%0b want v1", rsp_valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_sum !== '0 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL mid_async got v%0b %0h id%0d want v0 0 id0", rsp_valid, rsp_sum, rsp_id);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 64'(i), 64'd1);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL mid_first_grant got %b want 0001", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if (rsp_id !== 2'd0 || rsp_sum !== 64'd1) begin
      errors++; $display("FAIL mid_first_rsp got %0d id%0d want 1 id0", rsp_sum, rsp_id);
    end
    step();
  endtask

  task automatic test_lone();
    // rr_ptr is 1 here, so requester 2 is not the natural next pick
    set_op(2, 64'd2, 64'd3);
    set_op(3, 64'd4, 64'd4);
    set_op(0, 64'd9, 64'd9);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (req_ready !== 4'b0100) begin
        errors++; $display("FAIL lone_grant%0d got %b want 0100", c, req_ready);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 64'd5) begin
        errors++;
        $display("FAIL lone_rsp%0d got v%0b %0d id%0d want v1 5 id2", c, rsp_valid, rsp_sum,
                 rsp_id);
      end
    end
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL lone_next got %b want 1000", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if (rsp_id !== 2'd3 || rsp_sum !== 64'd8) begin
      errors++; $display("FAIL lone_next_rsp got %0d id%0d want 8 id3", rsp_sum, rsp_id);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_lone();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one DATA_W-bit adder among NUM_REQ requesters, e.g. the PC+4, branch-target and address-generation paths in the RISC-V core.
- Round-robin arbitration with a valid/ready handshake on each requester.
- One-entry registered result stage carries the sum and the winner's ID, with downstream backpressure.
- Sits between the datapath consumers and the single shared adder resource.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_W, 64, operand and sum width.
- ID_W is a localparam, not a parameter: ID_W = $clog2(NUM_REQ).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_a  input  NUM_REQ*DATA_W  operand A. Requester i occupies bits [i*DATA_W +: DATA_W].
- req_b  input  NUM_REQ*DATA_W  operand B, same packing as req_a.
- req_ready  output  NUM_REQ  one-hot grant. At most one bit is set per cycle.
- rsp_valid  output  1  result register holds a valid sum.
- rsp_ready  input  1  downstream accepts the result.
- rsp_sum  output  DATA_W  a+b of the granted request.
- rsp_id  output  ID_W  index of the requester that produced rsp_sum.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low; while reset==0 every register is cleared immediately.
- Reset values: rsp_valid=0, rsp_sum=0, rsp_id=0, rr_ptr=0.
  - req_ready is combinational, so it is 0 while reset is asserted.
  - A pending result is discarded on reset, with no partial output.
- Acceptance condition: can_accept = !rsp_valid || rsp_ready.
- Arbitration (combinational):
  - When can_accept=1, grant the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[i]=1 only for that i.
  - When can_accept=0, req_ready is all zeros.
- Transfer: occurs when req_valid[i] && req_ready[i]. On the next clock edge:
  - rsp_sum <= req_a[i] + req_b[i], truncated mod 2^DATA_W (carry dropped).
  - rsp_id <= i.
  - rsp_valid <= 1.
  - rr_ptr <= (i+1) mod NUM_REQ.
- Latency and throughput: one cycle from transfer to rsp_valid. Sustains one sum per cycle while rsp_ready=1.
- Drain: if rsp_valid && rsp_ready and no transfer happens that cycle, then rsp_valid <= 0. rsp_sum and rsp_id hold their last values.
- Simultaneous drain and accept: the old result leaves and the new result loads on the same edge. rsp_valid stays 1, with no bubble.
- Stall: when rsp_valid=1 and rsp_ready=0, rsp_sum, rsp_id and rsp_valid hold stable and no request is granted.
- rr_ptr is unchanged when no transfer occurs.
- Requester rules:
  - Requesters keep req_valid and their operands stable until the transfer completes.
  - req_valid must not depend combinationally on req_ready.
  - Dropping req_valid before the grant is legal and has no effect.
- Rotation: round-robin advances past the last winner only. A lone active requester wins every cycle.
- Wrap-around:
  - rr_ptr rolls from NUM_REQ-1 to 0.
  - For a non-power-of-two NUM_REQ, requester indices >= NUM_REQ never occur.
- rsp_ready is ignored while rsp_valid=0.

Optional Feature:
- Macro: ADDER_ARBITER_FLAGS_EN.
- Defined:
  - Adds output ports rsp_carry (1 bit) and rsp_ovf (1 bit).
  - rsp_carry is bit DATA_W of the (DATA_W+1)-bit unsigned sum.
  - rsp_ovf is signed overflow: operand MSBs equal and sum MSB different.
  - Both are registered with rsp_sum, follow the same hold/drain rules, and reset to 0.
- Undefined: the ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- Reset, then req_valid=0001 with a0=0x10, b0=0x20 and rsp_ready=1:
  - req_ready=0001 in the same cycle.
  - Next cycle: rsp_valid=1, rsp_sum=0x30, rsp_id=0.
- All four requesters valid continuously, rsp_ready=1, each with a_i=i and b_i=100:
  - Grants are 0,1,2,3,0 on consecutive cycles.
  - rsp_sum is 100,101,102,103,100.
  - No bubbles.
- Backpressure, a_1=5, b_1=6:
  - Hold rsp_ready=0 for 3 cycles after rsp_valid: req_ready=0000, rsp_sum=11 and rsp_id=1 stay stable.
  - Raise rsp_ready with req 2 valid: same-edge swap to req 2's result, rsp_valid stays 1.
- a=0xFFFF_FFFF_FFFF_FFFF, b=0x1:
  - rsp_sum=0.
  - With ADDER_ARBITER_FLAGS_EN: rsp_carry=1, rsp_ovf=0.
  - a=0x7FFF_FFFF_FFFF_FFFF, b=1 gives rsp_ovf=1, rsp_carry=0.
- Reset mid-operation: assert reset=0 asynchronously while rsp_valid=1 and rsp_ready=0.
  - rsp_valid drops without waiting for a clock edge.
  - After release, the first grant starts from requester 0.
- Lone requester 2 valid for 4 cycles with rsp_ready=1:
  - Requester 2 is granted every cycle.
  - rr_ptr ends at 3.
  - Requester 3 then wins over requester 0 when both assert together.
